// File: rtl/entity_table.sv
// -----------------------------------------------------------------------------
// entity_table
//   Entity register file behind the NIOS PIO entity interface. Holds
//   NUM_ENTITIES slots of {x, y, dir, active}. On each frame_tick a sweep FSM
//   walks every slot and steps each active one by STEP along its direction,
//   clamping it to the playfield. entity_read freezes the outputs so software
//   can read x and y without tearing.
//
//   Optional feature: define ENTITY_WRAP_EN to make motion wrap at the
//   playfield bounds instead of clamping.
//
// Ports
//   clk_clk           system clock
//   reset_reset_n     asynchronous reset, active low
//   frame_tick        one-cycle pulse per frame, starts a motion sweep
//   entity_select     slot index addressed by software
//   entity_read       level; rising edge snapshots the slot, high holds it
//   entity_write      level; rising edge writes dir/active
//   entity_place      level; rising edge writes x/y
//   entity_dir_in     direction: 0 up, 1 down, 2 left, 3 right
//   entity_active_in  active flag to write
//   entity_x_in       placement x
//   entity_y_in       placement y
//   entity_x/_y/_active/_dir  registered view of the selected slot
//   sweep_busy        high while the sweep FSM is in SWEEP
//   frame_overrun     sticky; frame_tick seen while a sweep was in progress
// -----------------------------------------------------------------------------
module entity_table #(
  parameter int unsigned NUM_ENTITIES = 8,
  parameter int unsigned SEL_W        = 3,
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned STEP         = 1,
  parameter int unsigned X_MIN        = 0,
  parameter int unsigned X_MAX        = 639,
  parameter int unsigned Y_MIN        = 0,
  parameter int unsigned Y_MAX        = 479
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               frame_tick,
  input  logic [SEL_W-1:0]   entity_select,
  input  logic               entity_read,
  input  logic               entity_write,
  input  logic               entity_place,
  input  logic [1:0]         entity_dir_in,
  input  logic               entity_active_in,
  input  logic [COORD_W-1:0] entity_x_in,
  input  logic [COORD_W-1:0] entity_y_in,
  output logic [COORD_W-1:0] entity_x,
  output logic [COORD_W-1:0] entity_y,
  output logic               entity_active,
  output logic [1:0]         entity_dir,
  output logic               sweep_busy,
  output logic               frame_overrun
);

  // One extra bit so an underflow below zero is visible.
  localparam int unsigned CW1 = COORD_W + 1;
  typedef logic [CW1-1:0]     wide_t;
  typedef logic [COORD_W-1:0] coord_t;

  localparam wide_t  STEP_W  = wide_t'(STEP);
  localparam wide_t  X_MIN_W = wide_t'(X_MIN);
  localparam wide_t  X_MAX_W = wide_t'(X_MAX);
  localparam wide_t  Y_MIN_W = wide_t'(Y_MIN);
  localparam wide_t  Y_MAX_W = wide_t'(Y_MAX);
  localparam coord_t X_MIN_C = coord_t'(X_MIN);
  localparam coord_t X_MAX_C = coord_t'(X_MAX);
  localparam coord_t Y_MIN_C = coord_t'(Y_MIN);
  localparam coord_t Y_MAX_C = coord_t'(Y_MAX);

  // Landing coordinate when a step crosses the low / high bound.
`ifdef ENTITY_WRAP_EN
  localparam coord_t X_UNDER = X_MAX_C;
  localparam coord_t X_OVER  = X_MIN_C;
  localparam coord_t Y_UNDER = Y_MAX_C;
  localparam coord_t Y_OVER  = Y_MIN_C;
`else
  localparam coord_t X_UNDER = X_MIN_C;
  localparam coord_t X_OVER  = X_MAX_C;
  localparam coord_t Y_UNDER = Y_MIN_C;
  localparam coord_t Y_OVER  = Y_MAX_C;
`endif

  typedef struct packed {
    coord_t     x;
    coord_t     y;
    logic [1:0] dir;
    logic       active;
  } slot_t;

  localparam slot_t RESET_SLOT = '{x: X_MIN_C, y: Y_MIN_C, dir: 2'd0, active: 1'b0};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Decrement one coordinate, substituting 'under' when it crosses 'lo'.
  function automatic coord_t step_dec(input coord_t c, input wide_t lo, input coord_t under);
    wide_t d;
    d = {1'b0, c} - STEP_W;
    if (d[COORD_W] || (d < lo)) step_dec = under;
    else                        step_dec = d[COORD_W-1:0];
  endfunction

  // Increment one coordinate, substituting 'over' when it crosses 'hi'.
  function automatic coord_t step_inc(input coord_t c, input wide_t hi, input coord_t over);
    wide_t s;
    s = {1'b0, c} + STEP_W;
    if (s > hi) step_inc = over;
    else        step_inc = s[COORD_W-1:0];
  endfunction

  // Slot after one motion step along its own direction.
  function automatic slot_t move(input slot_t s);
    move = s;
    case (s.dir)
      2'd0:    move.y = step_dec(s.y, Y_MIN_W, Y_UNDER);
      2'd1:    move.y = step_inc(s.y, Y_MAX_W, Y_OVER);
      2'd2:    move.x = step_dec(s.x, X_MIN_W, X_UNDER);
      default: move.x = step_inc(s.x, X_MAX_W, X_OVER);
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             step_en_c;
  logic             overrun_set_c;

  logic read_q, write_q, place_q;
  logic read_rise, write_rise, place_rise;

  slot_t slots_q [NUM_ENTITIES];
  slot_t slots_d [NUM_ENTITIES];
  slot_t sel_slot_c;

  assign read_rise  = entity_read  & ~read_q;
  assign write_rise = entity_write & ~write_q;
  assign place_rise = entity_place & ~place_q;

  // Sweep FSM state and index register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Sweep FSM next state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          state_d = S_SWEEP;
          idx_d   = '0;
        end
      end
      S_SWEEP: begin
        if (idx_q == SEL_W'(NUM_ENTITIES - 1)) state_d = S_DONE;
        else                                   idx_d   = idx_q + SEL_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sweep FSM decoded controls.
  always_comb begin
    step_en_c     = 1'b0;
    overrun_set_c = 1'b0;
    if (state_q == S_SWEEP) step_en_c = 1'b1;
    if (frame_tick && (state_q != S_IDLE)) overrun_set_c = 1'b1;
  end

  // Slot next values: sweep step first, then write (dir/active) and place (x/y)
  // override. The step reads the old dir/active; a place discards the step.
  always_comb begin
    for (int i = 0; i < NUM_ENTITIES; i++) begin
      slots_d[i] = slots_q[i];
      if (step_en_c && (idx_q == SEL_W'(i)) && slots_q[i].active)
        slots_d[i] = move(slots_q[i]);
      if (write_rise && (entity_select == SEL_W'(i))) begin
        slots_d[i].dir    = entity_dir_in;
        slots_d[i].active = entity_active_in;
      end
      if (place_rise && (entity_select == SEL_W'(i))) begin
        slots_d[i].x = entity_x_in;
        slots_d[i].y = entity_y_in;
      end
    end
  end

  // Slot storage.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_ENTITIES; i++) slots_q[i] <= RESET_SLOT;
    end else begin
      for (int i = 0; i < NUM_ENTITIES; i++) slots_q[i] <= slots_d[i];
    end
  end

  // Selected-slot mux; unimplemented indices read as zero.
  always_comb begin
    sel_slot_c = '0;
    for (int i = 0; i < NUM_ENTITIES; i++) begin
      if (entity_select == SEL_W'(i)) sel_slot_c = slots_q[i];
    end
  end

  // PIO edge detectors.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      place_q <= 1'b0;
    end else begin
      read_q  <= entity_read;
      write_q <= entity_write;
      place_q <= entity_place;
    end
  end

  // Output registers: track live while read is low, snapshot on read rise,
  // then hold until read falls.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      entity_x      <= '0;
      entity_y      <= '0;
      entity_active <= 1'b0;
      entity_dir    <= 2'd0;
    end else if (!entity_read || read_rise) begin
      entity_x      <= sel_slot_c.x;
      entity_y      <= sel_slot_c.y;
      entity_active <= sel_slot_c.active;
      entity_dir    <= sel_slot_c.dir;
    end
  end

  // Status registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sweep_busy    <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      sweep_busy <= (state_d == S_SWEEP);
      if (overrun_set_c) frame_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_entity_table.sv
module tb_entity_table;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic [2:0] entity_select;
  logic       entity_read, entity_write, entity_place;
  logic [1:0] entity_dir_in;
  logic       entity_active_in;
  logic [9:0] entity_x_in, entity_y_in;

  logic [9:0] x8, y8, x6, y6;
  logic       a8, a6, busy8, busy6, ovr8, ovr6;
  logic [1:0] d8, d6;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  entity_table dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .frame_tick(frame_tick),
    .entity_select(entity_select), .entity_read(entity_read),
    .entity_write(entity_write), .entity_place(entity_place),
    .entity_dir_in(entity_dir_in), .entity_active_in(entity_active_in),
    .entity_x_in(entity_x_in), .entity_y_in(entity_y_in),
    .entity_x(x8), .entity_y(y8), .entity_active(a8), .entity_dir(d8),
    .sweep_busy(busy8), .frame_overrun(ovr8)
  );

  entity_table #(.NUM_ENTITIES(6)) dut6 (
    .clk_clk(clk), .reset_reset_n(rst_n), .frame_tick(frame_tick),
    .entity_select(entity_select), .entity_read(entity_read),
    .entity_write(entity_write), .entity_place(entity_place),
    .entity_dir_in(entity_dir_in), .entity_active_in(entity_active_in),
    .entity_x_in(entity_x_in), .entity_y_in(entity_y_in),
    .entity_x(x6), .entity_y(y6), .entity_active(a6), .entity_dir(d6),
    .sweep_busy(busy6), .frame_overrun(ovr6)
  );

  typedef struct {
    int sel;
    int ex;
    int ey;
    int ea;
    int ed;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_place(input int sel, input int x, input int y);
    entity_select = 3'(sel);
    entity_x_in   = 10'(x);
    entity_y_in   = 10'(y);
    entity_place  = 1'b1;
    cyc(1);
    entity_place  = 1'b0;
    cyc(1);
  endtask

  task automatic do_write(input int sel, input int dir, input int act);
    entity_select    = 3'(sel);
    entity_dir_in    = 2'(dir);
    entity_active_in = 1'(act);
    entity_write     = 1'b1;
    cyc(1);
    entity_write     = 1'b0;
    cyc(1);
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic sel_rd(input int sel);
    entity_select = 3'(sel);
    cyc(1);
  endtask

  task automatic chk_slot8(input string nm, input int x, input int y, input int a, input int d);
    chk({nm, ".x"}, 32'(x8), 32'(x));
    chk({nm, ".y"}, 32'(y8), 32'(y));
    chk({nm, ".active"}, 32'(a8), 32'(a));
    chk({nm, ".dir"}, 32'(d8), 32'(d));
  endtask

  initial begin
    vec_t vecs [6];
    int   cnt;

    rst_n = 1'b0; frame_tick = 1'b0; entity_select = '0;
    entity_read = 1'b0; entity_write = 1'b0; entity_place = 1'b0;
    entity_dir_in = '0; entity_active_in = 1'b0; entity_x_in = '0; entity_y_in = '0;
    cyc(3);
    rst_n = 1'b1;

    // Reset state
    sel_rd(3);
    chk_slot8("reset_slot3", 0, 0, 0, 0);
    chk("reset_busy", 32'(busy8), 32'd0);
    chk("reset_overrun", 32'(ovr8), 32'd0);

    // Basic motion and sweep length
    do_place(2, 100, 50);
    do_write(2, 3, 1);
    do_tick();
    cnt = 0;
    for (int k = 0; k < 20 && busy8; k++) begin
      cnt++;
      cyc(1);
    end
    chk("busy_cycles", 32'(cnt), 32'd8);
    cyc(3);
    sel_rd(2);
    chk_slot8("slot2_step", 101, 50, 1, 3);
    sel_rd(1);
    chk_slot8("slot1_still", 0, 0, 0, 0);

    // Bounds on slot 0
    do_place(0, 639, 0);
    do_write(0, 3, 1);
    do_tick();
    cyc(12);
    sel_rd(0);
`ifdef ENTITY_WRAP_EN
    chk("x_bound", 32'(x8), 32'd0);
`else
    chk("x_bound", 32'(x8), 32'd639);
`endif
    do_write(0, 0, 1);
    do_tick();
    cyc(12);
    sel_rd(0);
`ifdef ENTITY_WRAP_EN
    chk("y_bound", 32'(y8), 32'd479);
    chk("y_bound_x", 32'(x8), 32'd0);
`else
    chk("y_bound", 32'(y8), 32'd0);
    chk("y_bound_x", 32'(x8), 32'd639);
`endif
    chk("no_overrun_yet", 32'(ovr8), 32'd0);

    // Snapshot: slot 2 at (103,50), hold across a sweep
    sel_rd(2);
    chk("pre_snap_x", 32'(x8), 32'd103);
    entity_read = 1'b1;
    cyc(1);
    do_tick();
    cyc(12);
    chk("snap_hold_x", 32'(x8), 32'd103);
    chk("snap_hold_y", 32'(y8), 32'd50);
    entity_read = 1'b0;
    cyc(1);
    chk("snap_release_x", 32'(x8), 32'd104);

    // Overrun: second tick 3 cycles later is ignored
    do_tick();
    cyc(2);
    do_tick();
    cyc(12);
    chk("overrun_set", 32'(ovr8), 32'd1);
    chk("overrun_single_step", 32'(x8), 32'd105);

    // Out-of-range select on the 6-slot instance
    do_write(7, 1, 1);
    do_place(7, 5, 5);
    cyc(1);
    chk("sel7_x6", 32'(x6), 32'd0);
    chk("sel7_y6", 32'(y6), 32'd0);
    chk("sel7_a6", 32'(a6), 32'd0);
    chk("sel7_d6", 32'(d6), 32'd0);
    chk_slot8("sel7_dut8", 5, 5, 1, 1);

`ifdef ENTITY_WRAP_EN
    vecs[0] = '{0, 0, 477, 1, 0};
`else
    vecs[0] = '{0, 639, 0, 1, 0};
`endif
    vecs[1] = '{1, 0, 0, 0, 0};
    vecs[2] = '{2, 105, 50, 1, 3};
    vecs[3] = '{3, 0, 0, 0, 0};
    vecs[4] = '{4, 0, 0, 0, 0};
    vecs[5] = '{5, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      sel_rd(vecs[i].sel);
      chk($sformatf("dut6_slot%0d.x", i), 32'(x6), 32'(vecs[i].ex));
      chk($sformatf("dut6_slot%0d.y", i), 32'(y6), 32'(vecs[i].ey));
      chk($sformatf("dut6_slot%0d.a", i), 32'(a6), 32'(vecs[i].ea));
      chk($sformatf("dut6_slot%0d.d", i), 32'(d6), 32'(vecs[i].ed));
    end
    chk("overrun_sticky", 32'(ovr8), 32'd1);

    // Reset in the middle of a sweep
    do_tick();
    cyc(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_overrun", 32'(ovr8), 32'd0);
    chk("midrst_x", 32'(x8), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    sel_rd(2);
    chk_slot8("midrst_slot2", 0, 0, 0, 0);
    cyc(3);
    chk("midrst_idle", 32'(busy8), 32'd0);

    // Write and place in the same cycle, held high across a sweep
    entity_select = 3'd4; entity_dir_in = 2'd1; entity_active_in = 1'b1;
    entity_x_in = 10'd20; entity_y_in = 10'd30;
    entity_write = 1'b1; entity_place = 1'b1;
    cyc(2);
    chk_slot8("wp_same_cycle", 20, 30, 1, 1);
    do_tick();
    cyc(12);
    chk_slot8("held_no_repeat", 20, 31, 1, 1);
    entity_write = 1'b0; entity_place = 1'b0;
    cyc(1);

    // Place on the slot being swept wins (slot 4 swept at 5th edge after tick)
    do_tick();
    cyc(4);
    entity_x_in = 10'd200; entity_y_in = 10'd200;
    entity_place = 1'b1;
    cyc(1);
    entity_place = 1'b0;
    cyc(12);
    chk_slot8("place_wins", 200, 200, 1, 1);

    // Write on the slot being swept: step uses old dir, new dir lands
    do_tick();
    cyc(4);
    entity_dir_in = 2'd3; entity_active_in = 1'b1;
    entity_write = 1'b1;
    cyc(1);
    entity_write = 1'b0;
    cyc(12);
    chk_slot8("write_vs_sweep", 200, 201, 1, 3);
    chk("final_overrun", 32'(ovr8), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
